// File: rtl/uart_rx_oversampler_pkg.sv
// Shared defaults and state encoding for the UART receive oversampler.
package uart_rx_oversampler_pkg;

   localparam int OVERSAMPLE_DEF  = 16;
   localparam int WIN_LO_DEF      = 6;
   localparam int WIN_HI_DEF      = 9;
   localparam int SYNC_STAGES_DEF = 2;
   localparam bit START_CHECK_DEF = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2
   } rx_state_e;

endpackage

// File: rtl/uart_rx_oversampler_sync.sv
// Reset-to-one multi-flop synchroniser for the asynchronous RX line.
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_r;

   // shift chain; idle line level is 1, so reset fills with ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_r <= {STAGES{1'b1}};
      end else begin
         chain_r <= {chain_r[STAGES-2:0], d};
      end
   end

   assign q = chain_r[STAGES-1];

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART RX oversampler: start-edge detect, windowed majority vote per bit,
// false-start rejection and noise flag; one registered bit per bit period.
module uart_rx_oversampler
   import uart_rx_oversampler_pkg::*;
#(
   parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
   parameter int WIN_LO      = WIN_LO_DEF,
   parameter int WIN_HI      = WIN_HI_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter bit START_CHECK = START_CHECK_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_en,
   input  logic in,
   input  logic stop,
   output logic out,
   output logic valid,
   output logic noise,
   output logic false_start,
   output logic busy
);

   localparam int PW = $clog2(OVERSAMPLE);
   localparam int CW = $clog2(WIN_HI - WIN_LO + 2);
   localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
   localparam logic [PW-1:0] PH_LO   = PW'(WIN_LO);
   localparam logic [PW-1:0] PH_HI   = PW'(WIN_HI);
   localparam logic [PW-1:0] PH_ONE  = PW'(1'b1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

   if ((OVERSAMPLE < 32'sd4) || (OVERSAMPLE > 32'sd64) || (WIN_LO < 32'sd0) ||
       (WIN_LO > WIN_HI) || (WIN_HI > OVERSAMPLE - 32'sd2) ||
       (SYNC_STAGES < 32'sd2)) begin : g_bad_param
      $error("uart_rx_oversampler: illegal parameter combination");
   end

   logic            in_s;
   rx_state_e       state_r, state_s;
   logic [PW-1:0]   phase_r, phase_s;
   logic [CW-1:0]   cnt0_r, cnt0_s, cnt1_r, cnt1_s;
   logic            out_r, out_s;
   logic            valid_r, valid_s;
   logic            noise_r, noise_s;
   logic            fs_r, fs_s;
   logic            busy_r;
   logic            bit_s;
   logic            in_win_s;

   uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (in),
      .q   (in_s)
   );

   assign bit_s    = (cnt1_r > cnt0_r);
   assign in_win_s = (phase_r >= PH_LO) && (phase_r <= PH_HI);

   // next state, sampling counters and pulse outputs
   always_comb begin
      state_s = state_r;
      phase_s = phase_r;
      cnt0_s  = cnt0_r;
      cnt1_s  = cnt1_r;
      out_s   = out_r;
      valid_s = 1'b0;
      noise_s = 1'b0;
      fs_s    = 1'b0;
      if (stop) begin
         state_s = IDLE;
         phase_s = {PW{1'b0}};
         cnt0_s  = {CW{1'b0}};
         cnt1_s  = {CW{1'b0}};
      end else if (tick_en) begin
         case (state_r)
            IDLE: begin
               if (!in_s) begin
                  state_s = START;
                  phase_s = {PW{1'b0}};
                  cnt0_s  = {CW{1'b0}};
                  cnt1_s  = {CW{1'b0}};
               end else begin
                  state_s = IDLE;
               end
            end
            START, DATA: begin
               if (phase_r == PH_LAST) begin
                  phase_s = {PW{1'b0}};
                  cnt0_s  = {CW{1'b0}};
                  cnt1_s  = {CW{1'b0}};
                  if ((state_r == START) && bit_s && START_CHECK) begin
                     fs_s    = 1'b1;
                     state_s = IDLE;
                  end else begin
                     valid_s = 1'b1;
                     out_s   = bit_s;
                     noise_s = (state_r == DATA) && (cnt0_r != {CW{1'b0}}) &&
                               (cnt1_r != {CW{1'b0}});
                     state_s = DATA;
                  end
               end else begin
                  phase_s = phase_r + PH_ONE;
                  // the decision tick itself takes no sample
                  if (in_win_s && in_s) begin
                     cnt1_s = cnt1_r + CNT_ONE;
                  end else if (in_win_s) begin
                     cnt0_s = cnt0_r + CNT_ONE;
                  end else begin
                     cnt0_s = cnt0_r;
                  end
               end
            end
            default: begin
               state_s = IDLE;
               phase_s = {PW{1'b0}};
               cnt0_s  = {CW{1'b0}};
               cnt1_s  = {CW{1'b0}};
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         phase_r <= {PW{1'b0}};
         cnt0_r  <= {CW{1'b0}};
         cnt1_r  <= {CW{1'b0}};
         out_r   <= 1'b1;
         valid_r <= 1'b0;
         noise_r <= 1'b0;
         fs_r    <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         phase_r <= phase_s;
         cnt0_r  <= cnt0_s;
         cnt1_r  <= cnt1_s;
         out_r   <= out_s;
         valid_r <= valid_s;
         noise_r <= noise_s;
         fs_r    <= fs_s;
         busy_r  <= (state_s != IDLE);
      end
   end

   assign out         = out_r;
   assign valid       = valid_r;
   assign noise       = noise_r;
   assign false_start = fs_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench: waveform tables per scenario, a tick-counting reference model of the
// receive rules, cycle-by-cycle comparison plus directed checks.
module tb_uart_rx_oversampler;

   localparam int OS   = 16;
   localparam int WL   = 6;
   localparam int WH   = 9;
   localparam int MAXN = 1024;

   logic clk = 1'b0;
   logic rst, tick_en, in, stop;
   logic out, valid, noise, false_start, busy;

   int total = 0;
   int bad   = 0;

   logic in_w[MAXN];
   logic tk_w[MAXN];
   logic sp_w[MAXN];
   logic e_valid[MAXN];
   logic e_fs[MAXN];
   logic e_noise[MAXN];
   logic e_out[MAXN];
   logic e_busy[MAXN];
   int   nlen;

   int obs_out[$];
   int obs_noise[$];
   int obs_edge[$];
   int obs_fs;

   uart_rx_oversampler dut (
      .clk         (clk),
      .rst         (rst),
      .tick_en     (tick_en),
      .in          (in),
      .stop        (stop),
      .out         (out),
      .valid       (valid),
      .noise       (noise),
      .false_start (false_start),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic clear_wave(input int n, input int tick_div);
      nlen = n;
      for (int e = 0; e < MAXN; e++) begin
         in_w[e] = 1'b1;
         tk_w[e] = ((e % tick_div) == 0);
         sp_w[e] = 1'b0;
      end
   endtask

   task automatic put_frame(input int f, input int per, input logic [7:0] d);
      logic b;
      for (int k = 0; k < 10; k++) begin
         if (k == 0) b = 1'b0;
         else if (k == 9) b = 1'b1;
         else b = d[k-1];
         for (int j = 0; j < per; j++) in_w[f + k*per + j] = b;
      end
   endtask

   // Reference: count ticks from the start edge; the line seen at edge e is
   // what was driven two edges earlier (two synchroniser flops).
   task automatic compute_model();
      int   mode, tc, ones, zeros;
      logic last, ins, b;
      mode = 0; tc = 0; ones = 0; zeros = 0; last = 1'b1;
      for (int e = 0; e < nlen; e++) begin
         e_valid[e] = 1'b0; e_fs[e] = 1'b0; e_noise[e] = 1'b0;
         if (sp_w[e]) begin
            mode = 0; tc = 0; ones = 0; zeros = 0;
         end else if (tk_w[e]) begin
            ins = (e >= 2) ? in_w[e-2] : 1'b1;
            if (mode == 0) begin
               if (!ins) begin mode = 1; tc = 0; ones = 0; zeros = 0; end
            end else begin
               tc++;
               if (tc == OS) begin
                  b = (ones > zeros);
                  if (mode == 1 && b) begin
                     e_fs[e] = 1'b1; mode = 0;
                  end else begin
                     e_valid[e] = 1'b1; last = b;
                     e_noise[e] = (mode == 2) && (ones > 0) && (zeros > 0);
                     mode = 2;
                  end
                  tc = 0; ones = 0; zeros = 0;
               end else if ((tc - 1) >= WL && (tc - 1) <= WH) begin
                  if (ins) ones++; else zeros++;
               end
            end
         end
         e_out[e]  = last;
         e_busy[e] = (mode != 0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in = 1'b1; tick_en = 1'b0; stop = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run();
      obs_out.delete(); obs_noise.delete(); obs_edge.delete(); obs_fs = 0;
      for (int e = 0; e < nlen; e++) begin
         @(negedge clk);
         in = in_w[e]; tick_en = tk_w[e]; stop = sp_w[e];
         @(posedge clk);
         #1;
         if (valid) begin obs_out.push_back(int'(out)); obs_noise.push_back(int'(noise)); obs_edge.push_back(e); end
         if (false_start) obs_fs++;
         total++; if (valid !== e_valid[e]) begin bad++; $display("FAIL valid edge=%0d got=%b exp=%b", e, valid, e_valid[e]); end
         total++; if (false_start !== e_fs[e]) begin bad++; $display("FAIL false_start edge=%0d got=%b exp=%b", e, false_start, e_fs[e]); end
         total++; if (noise !== e_noise[e]) begin bad++; $display("FAIL noise edge=%0d got=%b exp=%b", e, noise, e_noise[e]); end
         total++; if (out !== e_out[e]) begin bad++; $display("FAIL out edge=%0d got=%b exp=%b", e, out, e_out[e]); end
         total++; if (busy !== e_busy[e]) begin bad++; $display("FAIL busy edge=%0d got=%b exp=%b", e, busy, e_busy[e]); end
      end
      @(negedge clk);
      stop = 1'b0; tick_en = 1'b0; in = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      total++;
      if ({out, valid, noise, false_start, busy} !== 5'b10000) begin
         bad++;
         $display("FAIL %s got out/valid/noise/fs/busy=%b exp=10000", tag,
                  {out, valid, noise, false_start, busy});
      end
   endtask

   task automatic check_seq(input string tag, input logic [7:0] d, input int spacing);
      logic exp_b;
      total++;
      if (obs_out.size() != 9) begin
         bad++; $display("FAIL %s_count got=%0d exp=9", tag, obs_out.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            exp_b = (i == 0) ? 1'b0 : d[(i == 0) ? 0 : i-1];
            total++;
            if (obs_out[i] != int'(exp_b) || obs_noise[i] != 0) begin
               bad++; $display("FAIL %s_bit%0d got out=%0d noise=%0d exp out=%0d noise=0",
                               tag, i, obs_out[i], obs_noise[i], exp_b);
            end
            if (i > 0) begin
               total++;
               if (obs_edge[i] - obs_edge[i-1] != spacing) begin
                  bad++; $display("FAIL %s_gap%0d got=%0d exp=%0d", tag, i,
                                  obs_edge[i] - obs_edge[i-1], spacing);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in = 1'b1; tick_en = 1'b0; stop = 1'b0;
      #2;
      check_reset_outputs("reset_async");
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_held");
      do_reset();
   endtask

   task automatic test_clean_frame();
      do_reset();
      clear_wave(200, 1);
      put_frame(10, 16, 8'h55);
      sp_w[10 + 16*9 + 8] = 1'b1;
      compute_model();
      run();
      check_seq("clean", 8'h55, 16);
   endtask

   task automatic test_glitch();
      do_reset();
      clear_wave(60, 1);
      for (int e = 10; e < 13; e++) in_w[e] = 1'b0;
      compute_model();
      run();
      total++;
      if (obs_fs != 1 || obs_out.size() != 0 || busy !== 1'b0) begin
         bad++; $display("FAIL glitch got fs=%0d valids=%0d busy=%b exp fs=1 valids=0 busy=0",
                         obs_fs, obs_out.size(), busy);
      end
   endtask

   task automatic test_noise_and_tie(input bit tie);
      int f;
      f = 10;
      do_reset();
      clear_wave(200, 1);
      put_frame(f, 16, 8'h55);
      in_w[f + 16 + 8] = 1'b0;
      if (tie) in_w[f + 16 + 7] = 1'b0;
      sp_w[f + 16*9 + 8] = 1'b1;
      compute_model();
      run();
      total++;
      if (obs_out.size() < 2 || obs_out[1] != (tie ? 0 : 1) || obs_noise[1] != 1) begin
         bad++; $display("FAIL %s got pulses=%0d out=%0d noise=%0d exp out=%0d noise=1",
                         tie ? "tie" : "noise", obs_out.size(),
                         obs_out.size() > 1 ? obs_out[1] : -1,
                         obs_noise.size() > 1 ? obs_noise[1] : -1, tie ? 0 : 1);
      end
   endtask

   task automatic test_stop();
      int f, f2;
      f = 10; f2 = 100;
      do_reset();
      clear_wave(300, 1);
      put_frame(f, 16, 8'h55);
      for (int e = f + 64; e < f2; e++) in_w[e] = 1'b1;
      sp_w[f + 66] = 1'b1;
      put_frame(f2, 16, 8'hA3);
      sp_w[f2 + 16*9 + 8] = 1'b1;
      compute_model();
      run();
      total++;
      if (obs_out.size() != 12 || obs_out[3] != 0) begin
         bad++; $display("FAIL stop got pulses=%0d exp=12", obs_out.size());
      end
   endtask

   task automatic test_random();
      int f, r, idx;
      logic [7:0] d;
      for (int it = 0; it < 8; it++) begin
         do_reset();
         clear_wave(400, 1);
         if (it % 2 == 1) for (int e = 0; e < MAXN; e++) tk_w[e] = ($urandom_range(0, 7) != 0);
         f = $urandom_range(3, 20);
         d = 8'($urandom);
         put_frame(f, 16, d);
         for (int k = 0; k < 9; k++) begin
            r = $urandom_range(0, 3);
            for (int n = 0; n < r && n < 2; n++) begin
               idx = f + 16*k + $urandom_range(WL, WH) + 1;
               in_w[idx] = ~in_w[idx];
            end
         end
         if ($urandom_range(0, 2) == 0) sp_w[$urandom_range(f, f + 170)] = 1'b1;
         else sp_w[f + 16*12] = 1'b1;
         compute_model();
         run();
      end
   endtask

   task automatic test_slow_tick();
      do_reset();
      clear_wave(680, 4);
      put_frame(20, 64, 8'h55);
      sp_w[630] = 1'b1;
      compute_model();
      run();
      check_seq("slow", 8'h55, 64);
      do_reset();
      clear_wave(300, 4);
      put_frame(20, 64, 8'h3A);
      compute_model();
      run();
      rst = 1'b1;
      #1;
      check_reset_outputs("reset_midframe");
      @(negedge clk);
      rst = 1'b0;
      clear_wave(100, 1);
      compute_model();
      run();
   endtask

   initial begin
      test_reset();
      test_clean_frame();
      test_glitch();
      test_noise_and_tie(1'b0);
      test_noise_and_tie(1'b1);
      test_stop();
      test_random();
      test_slow_tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
